// File: rtl/prog_seq_counter.sv
// Purpose : programmable sequence counter; steps an index through a writable
//           value table (forward/reverse, loop or one-shot) with load-by-value search.
// Latency : index/flags register on the rising edge; out_data is table[idx] combinationally.
// Backpr. : none; en gates stepping, done freezes stepping until a successful load or rst.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en, dir         - step enable, direction (0 = +1, 1 = -1)
//   one_shot, last  - stop at sequence end instead of wrapping; final active index
//   load, in_data   - jump to first entry in 0..last equal to in_data
//   wr_en/addr/data - table write port (addresses >= DEPTH are dropped)
//   out_data/out_idx- current table value and index
//   wrap, load_miss - single-cycle event pulses
//   done            - sticky one-shot completion flag
module prog_seq_counter #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 8,
    localparam int IW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             one_shot,
    input  logic [IW-1:0]    last,
    input  logic             load,
    input  logic [WIDTH-1:0] in_data,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] out_data,
    output logic [IW-1:0]    out_idx,
    output logic             wrap,
    output logic             load_miss,
    output logic             done
);

    // Power-on table contents: a fixed 8-entry pattern, then the index itself.
    function automatic logic [WIDTH-1:0] init_val(input int i);
        int v;
        case (i)
            0:       v = 2;
            1:       v = 3;
            2:       v = 5;
            3:       v = 2;
            4:       v = 0;
            5:       v = 3;
            6:       v = 4;
            7:       v = 6;
            default: v = i;
        endcase
        return WIDTH'(v);
    endfunction

    logic [WIDTH-1:0] table_q [DEPTH];
    logic [IW-1:0]    idx_q, idx_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             miss_q, miss_d;

    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic [IW-1:0]    step_idx;
    logic             step_wrap;

    // Load search over the registered table, so a same-cycle write is not seen.
    // Scanning downward lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (IW'(i) <= last && table_q[i] == in_data) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // Candidate next index for a step. An index beyond last (after last was
    // lowered) folds to 0 going forward (a wrap) or to last going backward (no wrap).
    always_comb begin
        step_idx  = idx_q;
        step_wrap = 1'b0;
        if (!dir) begin
            if (idx_q < last) begin
                step_idx = idx_q + IW'(1);
            end else begin
                step_idx  = '0;
                step_wrap = 1'b1;
            end
        end else if (idx_q == '0) begin
            step_idx  = last;
            step_wrap = 1'b1;
        end else if (idx_q > last) begin
            step_idx = last;
        end else begin
            step_idx = idx_q - IW'(1);
        end
    end

    always_comb begin
        idx_d  = idx_q;
        done_d = done_q;
        wrap_d = 1'b0;
        miss_d = 1'b0;
        if (load) begin
            if (hit) begin
                idx_d  = hit_idx;
                done_d = 1'b0;
            end else begin
                miss_d = 1'b1;
            end
        end else if (en && !done_q) begin
            // One-shot turns the wrap into a stop: index holds on the final entry.
            if (step_wrap && one_shot) begin
                done_d = 1'b1;
            end else begin
                idx_d  = step_idx;
                wrap_d = step_wrap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
            wrap_q <= wrap_d;
            miss_q <= miss_d;
        end
    end

    // Table write compares against every legal index, so out-of-range addresses fall through.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= init_val(i);
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_addr == IW'(i)) begin
                    table_q[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (idx_q == IW'(i)) begin
                out_data = table_q[i];
            end
        end
    end

    assign out_idx   = idx_q;
    assign wrap      = wrap_q;
    assign load_miss = miss_q;
    assign done      = done_q;

endmodule

// File: tb/tb_prog_seq_counter.sv
// Purpose : self-checking bench for prog_seq_counter with a reference model feeding a scoreboard.
// Latency : one expected entry per clock, compared 1 time unit after the rising edge.
// Backpr. : none; stimulus is driven every cycle.
module tb_prog_seq_counter;
    localparam int W  = 3;
    localparam int D  = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, dir, one_shot, load, wr_en;
    logic [IW-1:0] last, wr_addr;
    logic [W-1:0]  in_data, wr_data;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          wrap, load_miss, done;

    prog_seq_counter #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .one_shot(one_shot),
        .last(last), .load(load), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out_data(out_data), .out_idx(out_idx), .wrap(wrap),
        .load_miss(load_miss), .done(done)
    );

    typedef struct packed {
        logic [W-1:0]  d;
        logic [IW-1:0] idx;
        logic          wrap;
        logic          miss;
        logic          done;
    } exp_t;

    exp_t          sb[$];
    logic [W-1:0]  m_tab [D];
    logic [IW-1:0] m_idx;
    logic          m_done, m_wrap, m_miss;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rst_val(input int i);
        logic [W-1:0] seed [8];
        seed = '{3'd2, 3'd3, 3'd5, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6};
        if (i < 8) return seed[i];
        return W'(i);
    endfunction

    // Reference behaviour for one clock edge, result pushed to the scoreboard.
    task automatic model_step();
        logic [W-1:0]  old [D];
        logic [IW-1:0] nx;
        bit            hit, wev;
        int            hi;
        old = m_tab;
        hit = 0;
        hi  = 0;
        wev = 0;
        nx  = m_idx;
        if (rst) begin
            m_idx  = '0;
            m_done = 1'b0;
            m_wrap = 1'b0;
            m_miss = 1'b0;
            for (int i = 0; i < D; i++) m_tab[i] = rst_val(i);
        end else begin
            m_wrap = 1'b0;
            m_miss = 1'b0;
            if (load) begin
                for (int i = 0; i <= int'(last); i++) begin
                    if (!hit && old[i] == in_data) begin
                        hit = 1;
                        hi  = i;
                    end
                end
                if (hit) begin
                    m_idx  = IW'(hi);
                    m_done = 1'b0;
                end else begin
                    m_miss = 1'b1;
                end
            end else if (en && !m_done) begin
                if (!dir) begin
                    if (m_idx < last) nx = m_idx + 3'd1;
                    else begin nx = '0; wev = 1; end
                end else if (m_idx == 0) begin
                    nx = last; wev = 1;
                end else if (m_idx > last) begin
                    nx = last;
                end else begin
                    nx = m_idx - 3'd1;
                end
                if (wev && one_shot) m_done = 1'b1;
                else begin
                    m_idx  = nx;
                    m_wrap = wev;
                end
            end
            if (wr_en) m_tab[wr_addr] = wr_data;
        end
        sb.push_back({m_tab[m_idx], m_idx, m_wrap, m_miss, m_done});
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("out_data",  32'(out_data),  32'(e.d));
        chk("out_idx",   32'(out_idx),   32'(e.idx));
        chk("wrap",      32'(wrap),      32'(e.wrap));
        chk("load_miss", 32'(load_miss), 32'(e.miss));
        chk("done",      32'(done),      32'(e.done));
    endtask

    task automatic quiet();
        rst = 0; en = 0; load = 0; wr_en = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        tick();
        rst = 0;
    endtask

    logic [W-1:0] seq_fwd [9];
    logic [W-1:0] seq_rev [8];

    initial begin
        seq_fwd = '{3'd2, 3'd3, 3'd5, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6, 3'd2};
        seq_rev = '{3'd6, 3'd4, 3'd3, 3'd0, 3'd2, 3'd5, 3'd3, 3'd2};
        dir = 0; one_shot = 0; last = 3'd7; in_data = '0; wr_addr = '0; wr_data = '0;
        quiet();

        // Reset state and forward loop with one wrap pulse.
        do_reset();
        chk("rst_data", 32'(out_data), 32'd2);
        chk("rst_idx",  32'(out_idx),  32'd0);
        en = 1;
        for (int k = 1; k < 9; k++) begin
            tick();
            chk("fwd_data", 32'(out_data), 32'(seq_fwd[k]));
            chk("fwd_wrap", 32'(wrap), (k == 8) ? 32'd1 : 32'd0);
        end
        tick();
        chk("wrap_drop", 32'(wrap), 32'd0);

        // Load hits: first match wins, then continue stepping.
        quiet(); load = 1; in_data = 3'd2; tick();
        chk("ld2_idx", 32'(out_idx), 32'd0);
        in_data = 3'd0; tick();
        chk("ld0_idx", 32'(out_idx), 32'd4);
        quiet(); en = 1; tick();
        chk("after_ld_a", 32'(out_data), 32'd3);
        tick();
        chk("after_ld_b", 32'(out_data), 32'd4);

        // Load misses: absent value, and value present only beyond last.
        quiet(); load = 1; in_data = 3'd7; tick();
        chk("miss7", 32'(load_miss), 32'd1);
        chk("miss7_idx", 32'(out_idx), 32'd6);
        quiet(); tick();
        chk("miss_drop", 32'(load_miss), 32'd0);
        last = 3'd3; load = 1; in_data = 3'd4; tick();
        chk("miss_last", 32'(load_miss), 32'd1);
        quiet(); last = 3'd7; tick();

        // Reverse loop from index 0.
        do_reset();
        dir = 1; en = 1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rev_data", 32'(out_data), 32'(seq_rev[k]));
        end

        // One-shot forward over 0..3, then hold with done set.
        dir = 0; one_shot = 1; last = 3'd3;
        do_reset();
        en = 1;
        for (int k = 0; k < 3; k++) tick();
        chk("os_end", 32'(out_data), 32'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("os_hold_data", 32'(out_data), 32'd2);
            chk("os_done",      32'(done),     32'd1);
            chk("os_nowrap",    32'(wrap),     32'd0);
        end
        load = 1; in_data = 3'd5; tick();
        chk("os_reload_done", 32'(done),    32'd0);
        chk("os_reload_idx",  32'(out_idx), 32'd2);
        quiet(); one_shot = 0; last = 3'd7;

        // Write to the live entry, then reset restores the table.
        do_reset();
        en = 1; tick();
        quiet(); wr_en = 1; wr_addr = 3'd1; wr_data = 3'd7; tick();
        chk("wr_live", 32'(out_data), 32'd7);
        quiet(); en = 1; tick(); tick();
        rst = 1; load = 1; in_data = 3'd6; wr_en = 1; wr_addr = 3'd1; wr_data = 3'd5; tick();
        chk("rst_ovr_idx",  32'(out_idx),  32'd0);
        chk("rst_ovr_data", 32'(out_data), 32'd2);
        quiet(); en = 1; tick();
        chk("rst_restore", 32'(out_data), 32'd3);

        // Randomised mix of every control, checked against the model.
        for (int k = 0; k < 600; k++) begin
            rst      = ($urandom_range(0, 60) == 0);
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 3) != 0);
            dir      = 1'($urandom_range(0, 1));
            one_shot = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) last = 3'($urandom_range(0, 7));
            in_data  = 3'($urandom_range(0, 7));
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 3'($urandom_range(0, 7));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
